// File: rtl/simple_phase_controller.sv
// Instruction-phase sequencer for the SIMPLE core: button run/stop control, phase stepping and retire count.
// Optional single-step button and STEP state are enabled with `define SINGLE_STEP_EN.
module simple_phase_controller #(
    parameter int NUM_PHASES  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exec,
`ifdef SINGLE_STEP_EN
    input  logic                  step,
`endif
    input  logic                  halt_req,
    output logic [2:0]            phase,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  running,
    output logic                  halted,
    output logic [15:0]           instr_count
);
    localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
`ifdef SINGLE_STEP_EN
        STEP,
`endif
        HALT
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             phase_q, phase_d;
    logic                   stop_pending_q, stop_pending_d;
    logic [15:0]            instr_count_q, instr_count_d;
    logic [NUM_PHASES-1:0]  phase_en_q, phase_en_d;
    logic                   running_q, running_d;
    logic                   halted_q, halted_d;

    logic [SYNC_STAGES-1:0] exec_sync_q, exec_sync_d;
    logic                   exec_prev_q, exec_prev_d;
    logic                   exec_p;
    logic                   in_step;

    // The exec button crosses clock domains, then a rising edge becomes a single-cycle pulse.
    always_comb begin
        exec_sync_d = {exec_sync_q[SYNC_STAGES-2:0], exec};
        exec_prev_d = exec_sync_q[SYNC_STAGES-1];
        exec_p      = exec_sync_q[SYNC_STAGES-1] & ~exec_prev_q;
    end

`ifdef SINGLE_STEP_EN
    logic [SYNC_STAGES-1:0] step_sync_q, step_sync_d;
    logic                   step_prev_q, step_prev_d;
    logic                   step_p;

    always_comb begin
        step_sync_d = {step_sync_q[SYNC_STAGES-2:0], step};
        step_prev_d = step_sync_q[SYNC_STAGES-1];
        step_p      = step_sync_q[SYNC_STAGES-1] & ~step_prev_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_sync_q <= '0;
            step_prev_q <= 1'b0;
        end else begin
            step_sync_q <= step_sync_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign in_step = (state_q == STEP);
`else
    assign in_step = 1'b0;
`endif

    // An exec pulse landing on the last-phase edge stops at that same boundary.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        stop_pending_d = stop_pending_q;
        instr_count_d  = instr_count_q;
        if (state_q == RUN || in_step) begin
            if (phase_q == LAST_PHASE) begin
                instr_count_d  = instr_count_q + 16'd1;
                phase_d        = '0;
                stop_pending_d = 1'b0;
                if (halt_req) begin
                    state_d = HALT;
                end else if (in_step || stop_pending_q || exec_p) begin
                    state_d = IDLE;
                end
            end else begin
                phase_d = phase_q + 3'd1;
                if (!in_step && exec_p) begin
                    stop_pending_d = 1'b1;
                end
            end
        end else if (exec_p) begin
            state_d = RUN;
            phase_d = '0;
        end
`ifdef SINGLE_STEP_EN
        else if (state_q == IDLE && step_p) begin
            state_d = STEP;
            phase_d = '0;
        end
`endif
    end

    always_comb begin
        running_d = (state_d == RUN);
`ifdef SINGLE_STEP_EN
        running_d = running_d || (state_d == STEP);
`endif
        halted_d   = (state_d == HALT);
        phase_en_d = '0;
        if (running_d) begin
            phase_en_d[phase_d] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exec_sync_q    <= '0;
            exec_prev_q    <= 1'b0;
            state_q        <= IDLE;
            phase_q        <= '0;
            stop_pending_q <= 1'b0;
            instr_count_q  <= '0;
            phase_en_q     <= '0;
            running_q      <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            exec_sync_q    <= exec_sync_d;
            exec_prev_q    <= exec_prev_d;
            state_q        <= state_d;
            phase_q        <= phase_d;
            stop_pending_q <= stop_pending_d;
            instr_count_q  <= instr_count_d;
            phase_en_q     <= phase_en_d;
            running_q      <= running_d;
            halted_q       <= halted_d;
        end
    end

    assign phase       = phase_q;
    assign phase_en    = phase_en_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_simple_phase_controller.sv
// Self-checking bench for simple_phase_controller: directed scenarios plus random buttons vs a cycle model.
module tb_simple_phase_controller;
    localparam int NP = 5;
    localparam int SS = 2;
    localparam int VW = 3 + NP + 1 + 1 + 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic exec = 1'b0;
    logic halt_req = 1'b0;
`ifdef SINGLE_STEP_EN
    logic step = 1'b0;
`endif
    logic [2:0]    phase;
    logic [NP-1:0] phase_en;
    logic          running;
    logic          halted;
    logic [15:0]   instr_count;
    logic [VW-1:0] dut_vec;

    int checks = 0;
    int passes = 0;

    simple_phase_controller #(.NUM_PHASES(NP), .SYNC_STAGES(SS)) dut (
        .clock       (clock),
        .reset       (reset),
        .exec        (exec),
`ifdef SINGLE_STEP_EN
        .step        (step),
`endif
        .halt_req    (halt_req),
        .phase       (phase),
        .phase_en    (phase_en),
        .running     (running),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    assign dut_vec = {phase, phase_en, running, halted, instr_count};

    // Behavioural model: button samples delayed by the synchronizer depth, mode plus phase counter.
    typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;
    mode_t       m_mode;
    int          m_phase;
    bit          m_stop;
    logic [15:0] m_count;
    bit          ex_hist [SS+1];
    bit          st_hist [SS+1];

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_phase = 0;
        m_stop  = 1'b0;
        m_count = '0;
        for (int i = 0; i <= SS; i++) begin
            ex_hist[i] = 1'b0;
            st_hist[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit ep;
        bit sp;
        bit stop_now;
        if (!reset) begin
            model_reset();
            return;
        end
        ep = ex_hist[SS-1] && !ex_hist[SS];
        sp = st_hist[SS-1] && !st_hist[SS];
        for (int i = SS; i > 0; i--) begin
            ex_hist[i] = ex_hist[i-1];
            st_hist[i] = st_hist[i-1];
        end
        ex_hist[0] = exec;
`ifdef SINGLE_STEP_EN
        st_hist[0] = step;
`endif
        case (m_mode)
            M_IDLE: begin
                if (ep) begin
                    m_mode = M_RUN;  m_phase = 0;
                end else if (sp) begin
                    m_mode = M_STEP; m_phase = 0;
                end
            end
            M_HALT: begin
                if (ep) begin
                    m_mode = M_RUN; m_phase = 0;
                end
            end
            default: begin
                if (m_phase == NP - 1) begin
                    m_count  = m_count + 16'd1;
                    m_phase  = 0;
                    stop_now = m_stop || (m_mode == M_RUN && ep) || (m_mode == M_STEP);
                    m_stop   = 1'b0;
                    if (halt_req)      m_mode = M_HALT;
                    else if (stop_now) m_mode = M_IDLE;
                end else begin
                    m_phase = m_phase + 1;
                    if (m_mode == M_RUN && ep) m_stop = 1'b1;
                end
            end
        endcase
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [NP-1:0] en;
        logic          exe;
        exe = (m_mode == M_RUN) || (m_mode == M_STEP);
        en  = '0;
        if (exe) en[m_phase] = 1'b1;
        return {3'(m_phase), en, exe, (m_mode == M_HALT), m_count};
    endfunction

    task automatic cycle();
        @(negedge clock);
        model_edge();
    endtask

    task automatic test_reset();
        reset = 1'b0; exec = 1'b0; halt_req = 1'b0;
        model_reset();
        repeat (3) cycle();
        checks++;
        if (dut_vec !== '0) $display("[TB] FAIL reset_held: got %h expected %h", dut_vec, {VW{1'b0}});
        else passes++;
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) $display("[TB] FAIL reset_idle_model: got %h expected %h", dut_vec, model_vec());
            else passes++;
            checks++;
            if (dut_vec !== '0) $display("[TB] FAIL reset_idle_zero: got %h expected %h", dut_vec, {VW{1'b0}});
            else passes++;
        end
    endtask

    task automatic test_run_start();
        exec = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) $display("[TB] FAIL run_model e%0d: got %h expected %h", e, dut_vec, model_vec());
            else passes++;
            if (e == 2) begin
                checks++;
                if (phase_en !== 5'b00000) $display("[TB] FAIL start_early: got %b expected %b", phase_en, 5'b00000);
                else passes++;
            end
            if (e == 3) begin
                checks++;
                if (phase_en !== 5'b00001) $display("[TB] FAIL start_latency: got %b expected %b", phase_en, 5'b00001);
                else passes++;
            end
            if (e == 18) begin
                checks++;
                if ({phase, instr_count} !== {3'd0, 16'd3}) $display("[TB] FAIL run_count: got %h expected %h", {phase, instr_count}, {3'd0, 16'd3});
                else passes++;
            end
            if (e == 4) exec = 1'b0;
        end
    endtask

    task automatic test_stop();
        exec = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) $display("[TB] FAIL stop_model i%0d: got %h expected %h", i, dut_vec, model_vec());
            else passes++;
            if (i == 4) begin
                checks++;
                if ({running, phase} !== {1'b1, 3'd4}) $display("[TB] FAIL stop_completes: got %h expected %h", {running, phase}, {1'b1, 3'd4});
                else passes++;
            end
            if (i == 5) begin
                checks++;
                if ({running, phase_en, instr_count} !== {1'b0, 5'b0, 16'd4}) $display("[TB] FAIL stop_idle: got %h expected %h", {running, phase_en, instr_count}, {1'b0, 5'b0, 16'd4});
                else passes++;
            end
            if (i == 2) exec = 1'b0;
        end
    endtask

    task automatic test_halt();
        logic [15:0] base;
        base = m_count;
        exec = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) $display("[TB] FAIL halt_model e%0d: got %h expected %h", e, dut_vec, model_vec());
            else passes++;
            if (e == 13) begin
                checks++;
                if ({halted, running, phase, phase_en, instr_count} !== {1'b1, 1'b0, 3'd0, 5'b0, base + 16'd2})
                    $display("[TB] FAIL halt_enter: got %h expected %h", {halted, running, phase, phase_en, instr_count}, {1'b1, 1'b0, 3'd0, 5'b0, base + 16'd2});
                else passes++;
            end
            if (e == 20) begin
                checks++;
                if ({halted, running, phase, phase_en} !== {1'b0, 1'b1, 3'd0, 5'b00001})
                    $display("[TB] FAIL halt_resume: got %h expected %h", {halted, running, phase, phase_en}, {1'b0, 1'b1, 3'd0, 5'b00001});
                else passes++;
            end
            case (e)
                2:  exec = 1'b0;
                10: begin exec = 1'b1; halt_req = 1'b1; end
                13: begin exec = 1'b0; halt_req = 1'b0; end
                17: exec = 1'b1;
                19: exec = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_wrap();
        reset = 1'b0;
        model_reset();
        cycle();
        reset = 1'b1;
        force dut.instr_count_q = 16'hFFFE;
        #1 release dut.instr_count_q;
        m_count = 16'hFFFE;
        checks++;
        if (instr_count !== 16'hFFFE) $display("[TB] FAIL wrap_preload: got %h expected %h", instr_count, 16'hFFFE);
        else passes++;
        exec = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) $display("[TB] FAIL wrap_model e%0d: got %h expected %h", e, dut_vec, model_vec());
            else passes++;
            if (e == 13) begin
                checks++;
                if (instr_count !== 16'h0000) $display("[TB] FAIL wrap_count: got %h expected %h", instr_count, 16'h0000);
                else passes++;
            end
            if (e == 2) exec = 1'b0;
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== '0) $display("[TB] FAIL async_reset: got %h expected %h", dut_vec, {VW{1'b0}});
        else passes++;
        cycle();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) $display("[TB] FAIL post_reset_model: got %h expected %h", dut_vec, model_vec());
            else passes++;
        end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_step();
        logic [15:0] base;
        int          pulses;
        base   = m_count;
        pulses = 0;
        step   = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) $display("[TB] FAIL step_model e%0d: got %h expected %h", e, dut_vec, model_vec());
            else passes++;
            if (phase_en !== '0) pulses++;
            if (e == 2) step = 1'b0;
        end
        checks++;
        if ({pulses[7:0], running, instr_count} !== {8'd5, 1'b0, base + 16'd1})
            $display("[TB] FAIL step_once: got %h expected %h", {pulses[7:0], running, instr_count}, {8'd5, 1'b0, base + 16'd1});
        else passes++;
        exec = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) $display("[TB] FAIL step_in_run e%0d: got %h expected %h", e, dut_vec, model_vec());
            else passes++;
            case (e)
                2: exec = 1'b0;
                6: step = 1'b1;
                8: step = 1'b0;
                default: ;
            endcase
        end
        checks++;
        if (running !== 1'b1) $display("[TB] FAIL step_ignored: got %b expected %b", running, 1'b1);
        else passes++;
    endtask
`endif

    task automatic test_random();
        reset = 1'b0; exec = 1'b0; halt_req = 1'b0;
        model_reset();
        cycle();
        reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) $display("[TB] FAIL random_model c%0d: got %h expected %h", c, dut_vec, model_vec());
            else passes++;
            if ($urandom_range(0, 5) == 0) exec = ~exec;
            halt_req = ($urandom_range(0, 3) == 0);
`ifdef SINGLE_STEP_EN
            if ($urandom_range(0, 7) == 0) step = ~step;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_run_start();
        test_stop();
        test_halt();
        test_wrap();
`ifdef SINGLE_STEP_EN
        test_step();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/simple_phase_controller.md
# simple_phase_controller

Instruction-phase sequencer for the SIMPLE processor core. It turns the front-panel exec button into run/stop control and steps the datapath through its fixed per-instruction phases. It stops cleanly at instruction boundaries on a stop request or a decoded HALT, and counts retired instructions. It sits between the board inputs and the processor datapath, and its `phase` output feeds the phase character display directly.

## Interface
Parameters:
- NUM_PHASES, 5, phases per instruction; legal range 2..8.
- SYNC_STAGES, 2, synchronizer depth for button inputs; minimum 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- exec  in  1  raw exec button, active-high, asynchronous to clock.
- step  in  1  raw single-step button, active-high; present only with SINGLE_STEP_EN.
- halt_req  in  1  datapath decode of HLT; meaningful only in the last phase.
- phase  out  3  current phase index, 0..NUM_PHASES-1; holds 0 when not executing.
- phase_en  out  NUM_PHASES  one-hot phase enable to the datapath; all zero when not executing.
- running  out  1  high in RUN (and STEP).
- halted  out  1  high in HALT.
- instr_count  out  16  retired-instruction counter.

## Operation
- Each button goes through SYNC_STAGES flops, then a rising-edge detector producing a one-cycle pulse (exec_p, step_p).
- States:
  - IDLE: not executing; this is the reset state.
  - RUN: executing continuously.
  - STEP: executing one instruction; exists only with the macro.
  - HALT: stopped by a decoded HLT.
- Transitions:
  - IDLE, exec_p -> RUN, with phase 0.
  - RUN, exec_p -> sets stop_pending. The current instruction completes. At the last-phase edge the block goes to IDLE and clears stop_pending.
  - RUN or STEP, last phase with halt_req=1 -> HALT. halt_req takes priority over stop_pending and over the STEP return; stop_pending is cleared.
  - HALT, exec_p -> RUN at phase 0; halted clears.
  - All other events are ignored. This includes exec_p while stop_pending is already set; no toggle back occurs.
- Phase counter:
  - Advances by 1 every cycle in RUN/STEP.
  - Wraps from NUM_PHASES-1 to 0 when execution continues.
  - phase_en = one-hot(phase) while in RUN/STEP, else 0.
- instr_count:
  - Increments at every edge leaving the last phase in RUN/STEP, including the edge that enters HALT.
  - Wraps 0xFFFF -> 0x0000.
  - Cleared only by reset.
- halt_req is ignored outside the last phase.

## Timing
- Reset values: phase=0, phase_en=0, running=0, halted=0, instr_count=0, stop_pending=0, all synchronizer and edge flops 0.
- Reset is asynchronous. Asserting it mid-instruction clears everything immediately; no instruction completes and no count occurs.
- Start latency with SYNC_STAGES=2: phase_en[0] rises after the 3rd rising edge at which exec is sampled high. Latency grows by one per extra stage.
- One instruction occupies exactly NUM_PHASES consecutive cycles. There are no bubbles between instructions in RUN.
- Stop/halt: after the last-phase edge, phase_en=0 and the state is IDLE or HALT in the same cycle.
- A button held high yields exactly one pulse. A new pulse requires the input to be sampled low first.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
SINGLE_STEP_EN:
- Defined:
  - The step port and the STEP state exist.
  - IDLE, step_p -> STEP at phase 0. The block runs exactly NUM_PHASES cycles, then returns to IDLE, or goes to HALT on halt_req.
  - running=1 during STEP.
  - exec_p is ignored in STEP.
  - step_p is ignored outside IDLE.
- Undefined: no step port, no STEP state. Behaviour is otherwise identical.

## Test plan
- Reset release, no buttons pressed, 20 cycles -> all outputs 0; state IDLE.
- exec pulse (high 4 cycles), halt_req=0 -> phase_en[0] after 3rd edge; phases cycle 0,1,2,3,4,0,...; instr_count=3 after 15 run cycles.
- Second exec pulse during phase 2 -> phases 3,4 complete, then phase_en=0, running=0, instr_count incremented once more.
- halt_req=1 held during phase 4 of the 2nd instruction, with a simultaneous exec pulse -> halted=1, instr_count=2, phase=0; a later exec pulse resumes at phase 0.
- Preload 0xFFFE retirements (force) then run 2 instructions -> instr_count 0x0000; reset asserted in phase 3 -> outputs 0 immediately.
- SINGLE_STEP_EN: step pulse in IDLE -> exactly 5 phase_en pulses, instr_count +1, back to IDLE; step pulse while in RUN -> ignored.
